// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// Instruction fetch: one imem request in flight, response loaded into IF/ID; 2 cycles/instr best case.
// Backpressure: address held until accepted; response refused while IF/ID full and decode stalled.
module ifu_fetch #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_flush,
  output logic              o_pcwen,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output logic [ADDR_W-1:0] o_imem_req_addr,
  input  logic              i_imem_rsp_valid,
  output logic              o_imem_rsp_ready,
  input  logic [INST_W-1:0] i_imem_rsp_data,
  input  logic              i_imem_rsp_err,
  output logic              o_ifid_valid,
  input  logic              i_ifid_ready,
  output logic [ADDR_W-1:0] o_ifid_pc,
  output logic [INST_W-1:0] o_ifid_inst,
  output logic              o_ifid_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              hold_q, hold_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] fetch_addr;
  logic              rsp_rdy;
  logic              load;

  // Once a request has been presented it must not change until accepted.
  assign fetch_addr = hold_q ? req_pc_q : i_pc;

  always_comb begin
    state_d          = state_q;
    hold_d           = hold_q;
    drop_d           = drop_q;
    req_pc_d         = req_pc_q;
    o_imem_req_valid = 1'b0;
    o_imem_req_addr  = '0;
    rsp_rdy          = 1'b0;
    load             = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        o_imem_req_valid = 1'b1;
        o_imem_req_addr  = fetch_addr;
        req_pc_d         = fetch_addr;
        // The request presented now is on the old path either way.
        if (i_flush) drop_d = 1'b1;
        if (i_imem_req_ready) begin
          state_d = S_WAIT;
          hold_d  = 1'b0;
        end else begin
          hold_d  = 1'b1;
        end
      end
      S_WAIT: begin
        rsp_rdy = drop_q | i_flush | ~o_ifid_valid | i_ifid_ready;
        if (i_imem_rsp_valid && rsp_rdy) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          load    = ~(drop_q | i_flush);
        end else if (i_flush) begin
          drop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_imem_rsp_ready = rsp_rdy;
  assign o_pcwen          = load | (i_flush & (state_q != S_IDLE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      hold_q   <= 1'b0;
      drop_q   <= 1'b0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Flush beats a same-cycle load; a drain with a load keeps the register full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ifid_valid <= 1'b0;
      o_ifid_pc    <= '0;
      o_ifid_inst  <= '0;
      o_ifid_err   <= 1'b0;
    end else if (i_flush) begin
      o_ifid_valid <= 1'b0;
    end else if (load) begin
      o_ifid_valid <= 1'b1;
      o_ifid_pc    <= req_pc_q;
      o_ifid_inst  <= i_imem_rsp_data;
      o_ifid_err   <= i_imem_rsp_err;
    end else if (i_ifid_ready) begin
      o_ifid_valid <= 1'b0;
    end
  end

  a_rsp_only_in_wait: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_imem_rsp_valid |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
// Directed bench for ifu_fetch: memory and PC-register environment, program-order delivery model.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc_reg;
  logic        i_flush;
  logic        o_pcwen;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [63:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic        o_imem_rsp_ready;
  logic [31:0] i_imem_rsp_data;
  logic        i_imem_rsp_err;
  logic        o_ifid_valid;
  logic        i_ifid_ready;
  logic [63:0] o_ifid_pc;
  logic [31:0] o_ifid_inst;
  logic        o_ifid_err;

  ifu_fetch #(.ADDR_W(64), .INST_W(32)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_pc             (pc_reg),
    .i_flush          (i_flush),
    .o_pcwen          (o_pcwen),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .o_imem_rsp_ready (o_imem_rsp_ready),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_imem_rsp_err   (i_imem_rsp_err),
    .o_ifid_valid     (o_ifid_valid),
    .i_ifid_ready     (i_ifid_ready),
    .o_ifid_pc        (o_ifid_pc),
    .o_ifid_inst      (o_ifid_inst),
    .o_ifid_err       (o_ifid_err)
  );

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          pcwen_cnt = 0;
  int          mem_lat = 0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;
  logic [63:0] flush_target = '0;
  logic [63:0] exp_pc = '0;
  logic [63:0] exp_req = '0;
  logic [63:0] deliv_pc[$];
  logic        deliv_err[$];
  int          load_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] mem_inst(input logic [63:0] a);
    return {a[15:0], 16'h0093};
  endfunction

  function automatic logic mem_err(input logic [63:0] a);
    return err_en && (a == err_addr);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_valid"}, o_imem_req_valid, 0);
    check({tag, "_req_addr"},  o_imem_req_addr,  0);
    check({tag, "_pcwen"},     o_pcwen,          0);
    check({tag, "_rsp_ready"}, o_imem_rsp_ready, 0);
    check({tag, "_ifid_valid"}, o_ifid_valid,    0);
    check({tag, "_ifid_pc"},   o_ifid_pc,        0);
    check({tag, "_ifid_inst"}, o_ifid_inst,      0);
    check({tag, "_ifid_err"},  o_ifid_err,       0);
  endtask

  // Instruction memory: one response per accepted request, mem_lat idle cycles first.
  logic        m_req_f, m_rsp_f, m_pend;
  logic [63:0] m_a, m_addr;
  int          m_cnt;
  initial begin
    m_pend = 1'b0; m_cnt = 0; m_addr = '0;
    i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0; i_imem_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      m_req_f = rst_n & o_imem_req_valid & i_imem_req_ready;
      m_rsp_f = rst_n & i_imem_rsp_valid & o_imem_rsp_ready;
      m_a     = o_imem_req_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_pend = 1'b0;
        i_imem_rsp_valid = 1'b0;
      end else begin
        if (m_rsp_f) begin
          m_pend = 1'b0;
          i_imem_rsp_valid = 1'b0;
        end
        if (m_req_f) begin
          check("one_outstanding", m_pend, 0);
          m_pend = 1'b1; m_cnt = mem_lat; m_addr = m_a;
        end
        if (m_pend && !i_imem_rsp_valid) begin
          if (m_cnt == 0) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_inst(m_addr);
            i_imem_rsp_err   = mem_err(m_addr);
          end else begin
            m_cnt--;
          end
        end
      end
    end
  end

  // PC register: redirect on flush, otherwise advance by 4 when written.
  logic        p_w, p_f;
  logic [63:0] p_t;
  initial forever begin
    @(negedge clk);
    p_w = o_pcwen; p_f = i_flush; p_t = flush_target;
    @(posedge clk);
    #1;
    if (rst_n && p_w) pc_reg = p_f ? p_t : pc_reg + 64'd4;
  end

  // Delivery model: decode must see instructions in program order from the
  // current PC stream, each carrying its own memory word and fault flag.
  logic prev_stall = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_pc = pc_reg;
      prev_stall = 1'b0;
    end else begin
      if (o_imem_req_valid) begin
        if (!prev_stall) exp_req = pc_reg;
        check("req_addr", o_imem_req_addr, exp_req);
      end else begin
        check("req_dropped_while_stalled", prev_stall, 0);
      end
      if (o_ifid_valid && i_ifid_ready && !i_flush) begin
        check("deliver_pc",   o_ifid_pc,   exp_pc);
        check("deliver_inst", o_ifid_inst, mem_inst(exp_pc));
        check("deliver_err",  o_ifid_err,  mem_err(exp_pc));
        exp_pc = exp_pc + 64'd4;
        deliv_pc.push_back(o_ifid_pc);
        deliv_err.push_back(o_ifid_err);
      end
      if (o_pcwen) pcwen_cnt++;
      if (o_pcwen && !i_flush) load_cyc.push_back(cyc);
      if (i_flush) exp_pc = flush_target;
      prev_stall = o_imem_req_valid & ~i_imem_req_ready;
    end
  end

  task automatic do_reset(input logic [63:0] pc, input int lat, input logic idr,
                          input logic rqr, input logic chk);
    rst_n = 1'b0; i_flush = 1'b0; flush_target = '0;
    pc_reg = pc; mem_lat = lat; i_ifid_ready = idr; i_imem_req_ready = rqr;
    repeat (3) tick();
    if (chk) begin
      sample();
      check_zero("reset");
    end
    tick();
    rst_n = 1'b1;
    deliv_pc.delete(); deliv_err.delete(); load_cyc.delete(); pcwen_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [63:0] t2_pc [4];
  logic        t2_err[4];
  int          n;
  logic        stale_seen, ifid_leak, addr_seen;
  logic [63:0] first_addr;
  int          flush_pcwen;

  initial begin
    rst_n = 1'b0; pc_reg = '0; i_flush = 1'b0;
    i_imem_req_ready = 1'b0; i_ifid_ready = 1'b0;
    t2_pc  = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};
    t2_err = '{1'b0, 1'b0, 1'b1, 1'b0};

    // T1: first fetch, then a full IF/ID refuses the next response until drained
    do_reset(64'h8000_0000, 0, 1'b0, 1'b1, 1'b1);
    sample();
    n = 0; while (!o_imem_req_valid && n < 10) begin sample(); n++; end
    check("t1_req_valid", o_imem_req_valid, 1);
    check("t1_req_addr", o_imem_req_addr, 64'h8000_0000);
    n = 0; while (!o_ifid_valid && n < 10) begin sample(); n++; end
    check("t1_ifid_valid", o_ifid_valid, 1);
    check("t1_ifid_pc", o_ifid_pc, 64'h8000_0000);
    check("t1_ifid_inst", o_ifid_inst, 32'h0000_0093);
    check("t1_ifid_err", o_ifid_err, 0);
    n = 0; while (!i_imem_rsp_valid && n < 10) begin sample(); n++; end
    check("t1_second_rsp_arrived", i_imem_rsp_valid, 1);
    check("t1_rsp_ready_when_full", o_imem_rsp_ready, 0);
    check("t1_pcwen_once", pcwen_cnt, 1);
    check("t1_ifid_pc_held", o_ifid_pc, 64'h8000_0000);
    tick(); i_ifid_ready = 1'b1; sample();
    check("t1_drain_load_pcwen", o_pcwen, 1);
    tick(); i_ifid_ready = 1'b0; sample();
    check("t1_refill_valid", o_ifid_valid, 1);
    check("t1_refill_pc", o_ifid_pc, 64'h8000_0004);
    check("t1_refill_inst", o_ifid_inst, 32'h0004_0093);

    // T2: zero-wait stream with a fault on the third fetch
    err_en = 1'b1; err_addr = 64'h8000_0008;
    do_reset(64'h8000_0000, 0, 1'b1, 1'b1, 1'b0);
    n = 0; while (deliv_pc.size() < 4 && n < 40) begin sample(); n++; end
    check("t2_delivered", deliv_pc.size(), 4);
    if (deliv_pc.size() >= 4 && load_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t2_pc%0d", i), deliv_pc[i], t2_pc[i]);
        check($sformatf("t2_err%0d", i), deliv_err[i], t2_err[i]);
      end
      for (int i = 1; i < 4; i++)
        check($sformatf("t2_gap%0d", i), load_cyc[i] - load_cyc[i-1], 2);
    end
    err_en = 1'b0;

    // T3: request stalled while the PC input wanders
    do_reset(64'h8000_0000, 0, 1'b1, 1'b0, 1'b0);
    sample();
    n = 0; while (!o_imem_req_valid && n < 10) begin sample(); n++; end
    check("t3_req_addr", o_imem_req_addr, 64'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      tick(); pc_reg = 64'h9000_0000 + 64'(i * 16); sample();
      check($sformatf("t3_stall_valid%0d", i), o_imem_req_valid, 1);
      check($sformatf("t3_stall_addr%0d", i), o_imem_req_addr, 64'h8000_0000);
    end
    tick(); pc_reg = 64'h8000_0000; i_imem_req_ready = 1'b1; sample();
    check("t3_accept_addr", o_imem_req_addr, 64'h8000_0000);
    n = 0; while (deliv_pc.size() < 1 && n < 20) begin sample(); n++; end
    check("t3_delivered", deliv_pc.size(), 1);
    if (deliv_pc.size() >= 1) check("t3_pc", deliv_pc[0], 64'h8000_0000);

    // T4: redirect while a fetch is outstanding; its response must vanish
    do_reset(64'h8000_0000, 2, 1'b0, 1'b1, 1'b0);
    sample();
    n = 0; while (!o_ifid_valid && n < 20) begin sample(); n++; end
    check("t4_first_load", o_ifid_valid, 1);
    n = 0; while (!(o_imem_req_valid && i_imem_req_ready) && n < 20) begin sample(); n++; end
    tick(); i_flush = 1'b1; flush_target = 64'h8000_0100; sample();
    check("t4_flush_pcwen", o_pcwen, 1);
    check("t4_rsp_not_yet", i_imem_rsp_valid, 0);
    tick(); i_flush = 1'b0;
    stale_seen = 1'b0; ifid_leak = 1'b0; addr_seen = 1'b0; first_addr = '0; flush_pcwen = 0;
    sample();
    n = 0;
    while (!o_pcwen && n < 30) begin
      if (o_ifid_valid) ifid_leak = 1'b1;
      if (i_imem_rsp_valid && o_imem_rsp_ready) stale_seen = 1'b1;
      if (o_imem_req_valid && !addr_seen) begin
        addr_seen = 1'b1; first_addr = o_imem_req_addr;
      end
      sample(); n++;
    end
    if (o_ifid_valid) ifid_leak = 1'b1;
    check("t4_stale_discarded", stale_seen, 1);
    check("t4_ifid_empty", ifid_leak, 0);
    check("t4_refetch_addr", first_addr, 64'h8000_0100);
    check("t4_new_load_pcwen", o_pcwen, 1);
    tick(); i_ifid_ready = 1'b1; sample();
    check("t4_new_valid", o_ifid_valid, 1);
    check("t4_new_pc", o_ifid_pc, 64'h8000_0100);
    check("t4_new_inst", o_ifid_inst, 32'h0100_0093);
    tick(); i_ifid_ready = 1'b0;

    // T5: asynchronous reset in the middle of a wait
    do_reset(64'h8000_0000, 5, 1'b0, 1'b1, 1'b0);
    sample();
    n = 0; while (!o_ifid_valid && n < 30) begin sample(); n++; end
    check("t5_loaded", o_ifid_valid, 1);
    n = 0; while (!(o_imem_req_valid && i_imem_req_ready) && n < 20) begin sample(); n++; end
    tick();
    #2 rst_n = 1'b0;
    #1 check_zero("areset");
    do_reset(64'h8000_0000, 0, 1'b1, 1'b1, 1'b0);
    n = 0; while (deliv_pc.size() < 1 && n < 20) begin sample(); n++; end
    check("t5_recover", deliv_pc.size(), 1);
    if (deliv_pc.size() >= 1) check("t5_recover_pc", deliv_pc[0], 64'h8000_0000);

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
